// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [3:0] {
        HOLD,
        INC,
        JMP,
        REL,
        CALL,
        RET,
        RETI,
        INT,
        CLR
    } pc_src_t;

    localparam int         DEF_W       = 8;
    localparam int         DEF_DEPTH   = 8;
    localparam logic [7:0] DEF_INT_VEC = 8'h04;

endpackage

// File: rtl/pc_stos_lifo.sv
// Return-address stack: a LIFO with full/empty flags and a combinational top-of-stack.
module pc_stos_lifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] tos,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    // When full the low bits wrap to 0, so top_idx still lands on DEPTH-1.
    assign wr_idx  = count[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign tos     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Storage is deliberately left without reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: jumps, calls/returns through a LIFO, and a single-level interrupt.
module pc_seq
    import pc_pkg::*;
#(
    parameter int             W       = DEF_W,
    parameter int             DEPTH   = DEF_DEPTH,
    parameter logic [W-1:0]   INT_VEC = W'(DEF_INT_VEC)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ID_rst,
    input  logic         stall,
    input  logic         skok_pc,
    input  logic         skok_wzgl,
    input  logic         call,
    input  logic         ret,
    input  logic         reti,
    input  logic         int_req,
    input  logic [W-1:0] adres_skok_pc,
    input  logic [7:0]   offset,
    output logic [W-1:0] PC_count,
    output logic         int_ack,
    output logic         stos_pusty,
    output logic         stos_pelny,
    output logic         blad_stosu
);

    pc_src_t      src;
    logic [W-1:0] pc;
    logic [W-1:0] pc_inc;
    logic [W-1:0] off_ext;
    logic [W-1:0] push_data;
    logic [W-1:0] tos;
    logic         push;
    logic         pop;
    logic         empty;
    logic         full;
    logic         int_en;
    logic         blad;

    assign pc_inc  = pc + W'(1);
    assign off_ext = W'($signed(offset));

    always_comb begin
        src = INC;
        if (ID_rst)                  src = CLR;
        else if (stall)              src = HOLD;
        else if (int_req && int_en)  src = INT;
        else if (reti)               src = RETI;
        else if (ret)                src = RET;
        else if (call)               src = CALL;
        else if (skok_pc)            src = JMP;
        else if (skok_wzgl)          src = REL;
    end

    // An interrupt saves the current PC so the interrupted instruction re-executes.
    assign push      = (src == CALL) || (src == INT);
    assign pop       = (src == RET) || (src == RETI);
    assign push_data = (src == INT) ? pc : pc_inc;

    pc_stos_lifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stos (
        .clk   (clk),
        .rst   (rst),
        .clr   (src == CLR),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .tos   (tos),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            int_en  <= 1'b1;
            int_ack <= 1'b0;
            blad    <= 1'b0;
        end else begin
            int_ack <= 1'b0;
            case (src)
                CLR: begin
                    pc     <= '0;
                    int_en <= 1'b1;
                    blad   <= 1'b0;
                end
                HOLD: ;
                INC:  pc <= pc_inc;
                JMP:  pc <= adres_skok_pc;
                REL:  pc <= pc + off_ext;
                CALL: begin
                    pc <= adres_skok_pc;
                    if (full) blad <= 1'b1;
                end
                INT: begin
                    pc      <= INT_VEC;
                    int_en  <= 1'b0;
                    int_ack <= 1'b1;
                    if (full) blad <= 1'b1;
                end
                RET: begin
                    pc <= empty ? '0 : tos;
                    if (empty) blad <= 1'b1;
                end
                RETI: begin
                    pc     <= empty ? '0 : tos;
                    int_en <= 1'b1;
                    if (empty) blad <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PC_count   = pc;
    assign stos_pusty = empty;
    assign stos_pelny = full;
    assign blad_stosu = blad;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq with a 4-deep stack; expected state is pushed per cycle and checked by a monitor.
module tb_pc_seq;

    localparam logic [8:0] C_RST = 9'h100;
    localparam logic [8:0] C_IDR = 9'h001;
    localparam logic [8:0] C_STL = 9'h002;
    localparam logic [8:0] C_JMP = 9'h004;
    localparam logic [8:0] C_REL = 9'h008;
    localparam logic [8:0] C_CAL = 9'h010;
    localparam logic [8:0] C_RET = 9'h020;
    localparam logic [8:0] C_RTI = 9'h040;
    localparam logic [8:0] C_INT = 9'h080;

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic       ack;
        logic       pusty;
        logic       pelny;
        logic       blad;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ID_rst = 1'b0;
    logic       stall = 1'b0;
    logic       skok_pc = 1'b0;
    logic       skok_wzgl = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       reti = 1'b0;
    logic       int_req = 1'b0;
    logic [7:0] adres_skok_pc = '0;
    logic [7:0] offset = '0;
    logic [7:0] PC_count;
    logic       int_ack;
    logic       stos_pusty;
    logic       stos_pelny;
    logic       blad_stosu;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    pc_seq #(
        .W       (8),
        .DEPTH   (4),
        .INT_VEC (8'h04)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_rst        (ID_rst),
        .stall         (stall),
        .skok_pc       (skok_pc),
        .skok_wzgl     (skok_wzgl),
        .call          (call),
        .ret           (ret),
        .reti          (reti),
        .int_req       (int_req),
        .adres_skok_pc (adres_skok_pc),
        .offset        (offset),
        .PC_count      (PC_count),
        .int_ack       (int_ack),
        .stos_pusty    (stos_pusty),
        .stos_pelny    (stos_pelny),
        .blad_stosu    (blad_stosu)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [8:0] ctl, input logic [7:0] addr, input logic [7:0] off,
                                 input logic [7:0] e_pc, input logic e_ack, input logic e_pusty,
                                 input logic e_pelny, input logic e_blad, input string name);
        exp_t e;
        @(negedge clk);
        rst           = ctl[8];
        int_req       = ctl[7];
        reti          = ctl[6];
        ret           = ctl[5];
        call          = ctl[4];
        skok_wzgl     = ctl[3];
        skok_pc       = ctl[2];
        stall         = ctl[1];
        ID_rst        = ctl[0];
        adres_skok_pc = addr;
        offset        = off;
        e.name  = name;
        e.pc    = e_pc;
        e.ack   = e_ack;
        e.pusty = e_pusty;
        e.pelny = e_pelny;
        e.blad  = e_blad;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if (PC_count !== e.pc || int_ack !== e.ack || stos_pusty !== e.pusty ||
            stos_pelny !== e.pelny || blad_stosu !== e.blad) begin
            $display("[TB] FAIL %s: got pc=%h ack=%b pusty=%b pelny=%b blad=%b, expected pc=%h ack=%b pusty=%b pelny=%b blad=%b",
                     e.name, PC_count, int_ack, stos_pusty, stos_pelny, blad_stosu,
                     e.pc, e.ack, e.pusty, e.pelny, e.blad);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    initial begin
        applyStimulus(C_RST, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, "reset_0");
        applyStimulus(C_RST, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, "reset_1");
        for (int i = 1; i <= 5; i++)
            applyStimulus(9'h000, 8'h00, 8'h00, 8'(i), 0, 1, 0, 0, "free_inc");

        applyStimulus(C_JMP, 8'hFF, 8'h00, 8'hFF, 0, 1, 0, 0, "jmp_ff");
        applyStimulus(9'h000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, "inc_wrap");
        applyStimulus(C_JMP, 8'h05, 8'h00, 8'h05, 0, 1, 0, 0, "jmp_05");
        applyStimulus(C_REL, 8'h00, 8'hF8, 8'hFD, 0, 1, 0, 0, "rel_neg");
        applyStimulus(C_REL, 8'h00, 8'h03, 8'h00, 0, 1, 0, 0, "rel_wrap");

        applyStimulus(C_JMP, 8'h10, 8'h00, 8'h10, 0, 1, 0, 0, "jmp_10");
        applyStimulus(C_CAL, 8'h40, 8'h00, 8'h40, 0, 0, 0, 0, "call_40");
        applyStimulus(9'h000, 8'h00, 8'h00, 8'h41, 0, 0, 0, 0, "sub_41");
        applyStimulus(9'h000, 8'h00, 8'h00, 8'h42, 0, 0, 0, 0, "sub_42");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h11, 0, 1, 0, 0, "ret_11");

        applyStimulus(C_JMP, 8'h20, 8'h00, 8'h20, 0, 1, 0, 0, "jmp_20");
        applyStimulus(C_INT, 8'h00, 8'h00, 8'h04, 1, 0, 0, 0, "int_take");
        applyStimulus(C_INT, 8'h00, 8'h00, 8'h05, 0, 0, 0, 0, "int_masked_a");
        applyStimulus(C_INT, 8'h00, 8'h00, 8'h06, 0, 0, 0, 0, "int_masked_b");
        applyStimulus(C_RTI, 8'h00, 8'h00, 8'h20, 0, 1, 0, 0, "reti_20");
        applyStimulus(C_INT, 8'h00, 8'h00, 8'h04, 1, 0, 0, 0, "int_reenabled");
        applyStimulus(C_RTI, 8'h00, 8'h00, 8'h20, 0, 1, 0, 0, "reti_again");

        applyStimulus(C_IDR | C_CAL, 8'h40, 8'h00, 8'h00, 0, 1, 0, 0, "idrst_prio");

        applyStimulus(C_JMP, 8'h30, 8'h00, 8'h30, 0, 1, 0, 0, "jmp_30");
        applyStimulus(C_CAL, 8'h50, 8'h00, 8'h50, 0, 0, 0, 0, "call_1");
        applyStimulus(C_CAL, 8'h60, 8'h00, 8'h60, 0, 0, 0, 0, "call_2");
        applyStimulus(C_CAL, 8'h70, 8'h00, 8'h70, 0, 0, 0, 0, "call_3");
        applyStimulus(C_CAL, 8'h80, 8'h00, 8'h80, 0, 0, 1, 0, "call_4_full");
        applyStimulus(C_CAL, 8'h90, 8'h00, 8'h90, 0, 0, 1, 1, "call_5_ovf");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h71, 0, 0, 0, 1, "ret_71");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h61, 0, 0, 0, 1, "ret_61");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h51, 0, 0, 0, 1, "ret_51");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h31, 0, 1, 0, 1, "ret_31");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, "ret_underflow");
        applyStimulus(C_IDR, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, "idrst_clear");

        applyStimulus(C_JMP, 8'h20, 8'h00, 8'h20, 0, 1, 0, 0, "jmp_20_b");
        applyStimulus(C_STL | C_CAL | C_RET | C_INT, 8'h40, 8'h00, 8'h20, 0, 1, 0, 0, "stall_a");
        applyStimulus(C_STL | C_CAL | C_RET | C_INT, 8'h40, 8'h00, 8'h20, 0, 1, 0, 0, "stall_b");
        applyStimulus(C_CAL | C_RET | C_INT, 8'h40, 8'h00, 8'h04, 1, 0, 0, 0, "release_int");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h20, 0, 1, 0, 0, "depth_one");

        applyStimulus(C_CAL, 8'h40, 8'h00, 8'h40, 0, 0, 0, 0, "call_pre_rst");
        applyStimulus(C_RST, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, "rst_mid_call");
        applyStimulus(9'h000, 8'h00, 8'h00, 8'h01, 0, 1, 0, 0, "post_rst_inc");
        applyStimulus(C_RET, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, "ret_after_rst");

        applyStimulus(9'h000, 8'h00, 8'h00, 8'h01, 0, 1, 0, 1, "inc_sticky");
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter W, default 8: program-counter and address width in bits.
REQ-002 Parameter DEPTH, default 8: return-address stack depth in entries, power of two, minimum 2.
REQ-003 Parameter INT_VEC, default 8'h04 resized to W: interrupt vector address.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port ID_rst, input, 1: synchronous clear from the decoder.
REQ-007 Port stall, input, 1: hold PC and stack.
REQ-008 Port skok_pc, input, 1: absolute jump to adres_skok_pc.
REQ-009 Port skok_wzgl, input, 1: relative jump, PC + sign-extended offset.
REQ-010 Port call, input, 1: push PC+1, then jump to adres_skok_pc.
REQ-011 Port ret, input, 1: pop the top of stack into PC.
REQ-012 Port reti, input, 1: pop the top of stack into PC and re-enable interrupts.
REQ-013 Port int_req, input, 1: level interrupt request.
REQ-014 Port adres_skok_pc, input, W: absolute target address.
REQ-015 Port offset, input, 8: signed two's-complement relative offset.
REQ-016 Port PC_count, output, W: current program counter.
REQ-017 Port int_ack, output, 1: one-cycle pulse when an interrupt is taken.
REQ-018 Port stos_pusty / stos_pelny, output, 1 each: stack empty / stack full.
REQ-019 Port blad_stosu, output, 1: sticky stack overflow/underflow flag.

Function
REQ-020 Exactly one action SHALL be applied per cycle, chosen by this priority:
- rst
- ID_rst
- stall
- interrupt
- reti
- ret
- call
- skok_pc
- skok_wzgl
- increment
REQ-021 Increment SHALL be PC+1 modulo 2^W, so all-ones wraps to 0.
REQ-022 A relative jump SHALL compute PC + sign-extended offset modulo 2^W; the offset is relative to the jump instruction's own PC.
REQ-023 An interrupt SHALL be taken when int_req=1, int_en=1, and stall=0:
- push the current PC (the interrupted instruction is not consumed)
- set PC to INT_VEC
- clear int_en
- pulse int_ack for one cycle
REQ-024 call SHALL push PC+1 (wrapped) and load adres_skok_pc.
REQ-025 ret and reti SHALL load the popped value unmodified.
- reti SHALL also set int_en.
REQ-026 A push when stos_pelny=1 SHALL:
- leave the stack and its pointer unchanged
- set blad_stosu
- still perform the jump
REQ-027 A pop when stos_pusty=1 SHALL:
- load PC=0
- set blad_stosu
- leave the pointer unchanged
- still set int_en if the pop is a reti
REQ-028 When several requests are active at once, lower-priority requests SHALL be ignored with no side effects on the stack or flags.
REQ-029 stall=1 SHALL freeze PC, stack, and int_en, and SHALL block interrupt acceptance.
REQ-030 ID_rst SHALL have the same effect as rst (REQ-032), but synchronously.
REQ-031 Stack flags SHALL be registered-state derived, valid in the same cycle as the pointer:
- stos_pusty = (count==0)
- stos_pelny = (count==DEPTH)

Reset
REQ-032 While rst=1, all state SHALL be held in these values, with no dependency on clk:
- PC_count=0
- stack count=0
- int_en=1
- int_ack=0
- blad_stosu=0
- stos_pusty=1
- stos_pelny=0
REQ-033 Stack storage contents SHALL NOT be reset; only the pointer is reset.
REQ-034 A reset asserted mid-interrupt or mid-call SHALL discard all pending stack state.

Structure
REQ-035 A shared package pc_pkg SHALL hold:
- the pc_src_t enum (HOLD, INC, JMP, REL, CALL, RET, RETI, INT, CLR)
- default parameter constants
REQ-036 The block SHALL contain one sub-module, pc_stos_lifo (parametrised W and DEPTH), with:
- push/pop with full/empty
- a combinational top-of-stack output
REQ-037 Action selection SHALL be a combinational priority decoder producing pc_src_t.

Verification
REQ-038 Reset then 5 free cycles -> PC_count = 0,1,2,3,4; stos_pusty=1.
REQ-039 At PC=8'h10, call to 8'h40, then ret at 8'h42 -> PC 8'h40, 8'h41, 8'h42, 8'h11.
REQ-040 At PC=8'h20, int_req high -> PC=8'h04 and int_ack one cycle; then at 8'h06 int_req is still high -> no re-entry; reti -> PC=8'h20, int_en=1.
REQ-041 DEPTH=4: five calls -> fifth call jumps, blad_stosu=1, and four rets return the first four addresses in LIFO order; ret on empty -> PC=0.
REQ-042 At PC=8'h05 with skok_wzgl and offset=-8 -> PC=8'hFD; at PC=8'hFF increment -> 8'h00.
REQ-043 call, ret, and int_req asserted together with stall=1 -> no change for the stall cycles; on release -> interrupt wins and the stack depth grows by exactly 1.
